// File: rtl/gate_pkg.sv
// Shared definitions for the gate ingress steering stage.
// Holds the route-byte field layout, the capability word layout and the
// demux FSM state encoding.
package gate_pkg;

    localparam int unsigned ROUTE_BITS      = 8;
    localparam int unsigned ROUTE_DEST_LSB  = 0;
    localparam int unsigned ROUTE_DEST_BITS = 2;
    localparam int unsigned MAX_DESTS       = 1 << ROUTE_DEST_BITS;

    // Capability word doubles as the allowed route byte: low bits select the entry.
    typedef struct packed {
        logic [ROUTE_BITS-ROUTE_DEST_BITS-1:0] tag;
        logic [ROUTE_DEST_BITS-1:0]            idx;
    } cap_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } gate_demux_state_t;

endpackage

// File: rtl/gate_cap_table.sv
// Per-destination capability table with admit compare.
// Ports:
//   aclk, aresetn  clock and synchronous active-low reset
//   wr_en, wr_word write port; entry wr_word.idx gets the full word, valid set
//   lkp_word       route byte to check
//   admit_c        combinational: entry exists, is valid and equals the route byte
module gate_cap_table
    import gate_pkg::*;
#(
    parameter int unsigned N_DESTS = 4
) (
    input  logic      aclk,
    input  logic      aresetn,
    input  logic      wr_en,
    input  cap_word_t wr_word,
    input  cap_word_t lkp_word,
    output logic      admit_c
);

    cap_word_t                  entry [MAX_DESTS];
    logic [MAX_DESTS-1:0]       vld;
    logic [ROUTE_DEST_BITS-1:0] wr_idx;
    logic [ROUTE_DEST_BITS-1:0] lkp_idx;

    assign wr_idx  = wr_word[ROUTE_DEST_LSB +: ROUTE_DEST_BITS];
    assign lkp_idx = lkp_word[ROUTE_DEST_LSB +: ROUTE_DEST_BITS];

    // Table storage; valid bits only clear on reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld <= '0;
            for (int i = 0; i < int'(MAX_DESTS); i++) begin
                entry[i] <= '0;
            end
        end else if (wr_en && (32'(wr_idx) < 32'(N_DESTS))) begin
            entry[wr_idx] <= wr_word;
            vld[wr_idx]   <= 1'b1;
        end
    end

    // Reads registered contents, so a same-cycle write never affects the result.
    assign admit_c = (32'(lkp_idx) < 32'(N_DESTS)) && vld[lkp_idx]
                     && (entry[lkp_idx] == lkp_word);

endmodule

// File: rtl/gate_route_demux.sv
// Ingress steering demux for the gate receive logic.
// Reads the route byte of each packet's first beat, checks it against the
// capability table, then forwards the whole packet to one destination or
// drops it and counts the drop.
// Ports:
//   aclk, aresetn        clock and synchronous active-low reset
//   cap_wr, cap_data     capability table write
//   s_t*                 ingress AXI4-Stream
//   m_tvalid/m_tready    per-destination handshake
//   m_tdata/tkeep/tlast  shared egress payload (combinational pass-through)
//   ul_port_out          destination of the current or last admitted packet
//   drop_cnt             saturating count of dropped packets
module gate_route_demux
    import gate_pkg::*;
#(
    parameter int unsigned N_DESTS   = 4,
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned ROUTE_LSB = 0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cap_wr,
    input  logic [7:0]             cap_data,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [DATA_BITS-1:0]   s_tdata,
    input  logic [DATA_BITS/8-1:0] s_tkeep,
    input  logic                   s_tlast,
    output logic [N_DESTS-1:0]     m_tvalid,
    input  logic [N_DESTS-1:0]     m_tready,
    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic [1:0]             ul_port_out,
    output logic [31:0]            drop_cnt
);

    gate_demux_state_t          state;
    gate_demux_state_t          state_nxt;
    logic [ROUTE_DEST_BITS-1:0] dest_q;
    logic [ROUTE_DEST_BITS-1:0] dest_nxt;
    cap_word_t                  route;
    logic                       admit_c;
    logic                       sel_ready_c;
    logic                       drop_done_c;

    assign route = s_tdata[ROUTE_LSB +: ROUTE_BITS];

    gate_cap_table #(
        .N_DESTS (N_DESTS)
    ) u_cap_table (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_en    (cap_wr),
        .wr_word  (cap_data),
        .lkp_word (route),
        .admit_c  (admit_c)
    );

    // Ready of the currently selected sink.
    always_comb begin
        sel_ready_c = 1'b0;
        for (int i = 0; i < int'(N_DESTS); i++) begin
            if (dest_q == ROUTE_DEST_BITS'(i)) begin
                sel_ready_c = m_tready[i];
            end
        end
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; m_tvalid never looks at m_tready.
    always_comb begin
        state_nxt   = state;
        dest_nxt    = dest_q;
        s_tready    = 1'b0;
        m_tvalid    = '0;
        drop_done_c = 1'b0;
        case (state)
            ST_IDLE: begin
                // First beat stays held; decision costs one bubble cycle.
                if (s_tvalid) begin
                    if (admit_c) begin
                        state_nxt = ST_FWD;
                        dest_nxt  = route.idx;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                s_tready = sel_ready_c;
                for (int i = 0; i < int'(N_DESTS); i++) begin
                    m_tvalid[i] = s_tvalid && (dest_q == ROUTE_DEST_BITS'(i));
                end
                if (s_tvalid && sel_ready_c && s_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    drop_done_c = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Selected destination and saturating drop counter.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            dest_q   <= '0;
            drop_cnt <= '0;
        end else begin
            dest_q <= dest_nxt;
            if (drop_done_c && (drop_cnt != 32'hFFFF_FFFF)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    assign ul_port_out = 2'(dest_q);
    assign m_tdata     = s_tdata;
    assign m_tkeep     = s_tkeep;
    assign m_tlast     = s_tlast;

endmodule

// File: doc/gate_route_demux.md
Name: gate_route_demux

Overview:
- Ingress steering stage that feeds the gate receive logic.
- Takes one AXI4-Stream packet at a time and reads the route byte from its first beat.
- Checks that route byte against a host-programmed per-destination capability table.
- Admitted packets are forwarded whole to one of N_DESTS output streams, and the selected port is exported on ul_port_out. Packets that fail the check are dropped and counted.

Parameters:
- N_DESTS, 4, number of destination streams (1..4; the route byte carries a 2-bit destination field).
- DATA_BITS, 512, stream data width (multiple of 8).
- ROUTE_LSB, 0, bit offset of the route byte within first-beat s_tdata (multiple of 8, ≤ DATA_BITS-8).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low; clock aclk
- cap_wr  in  1  capability write strobe
- cap_data  in  8  capability word: [1:0] destination index, [7:0] full word is the allowed route byte
- s_tvalid  in  1  ingress valid
- s_tready  out  1  ingress ready
- s_tdata  in  DATA_BITS  ingress data
- s_tkeep  in  DATA_BITS/8  ingress byte enables
- s_tlast  in  1  ingress last beat
- m_tvalid  out  N_DESTS  per-destination valid
- m_tready  in  N_DESTS  per-destination ready
- m_tdata  out  DATA_BITS  shared egress data
- m_tkeep  out  DATA_BITS/8  shared egress keep
- m_tlast  out  1  shared egress last
- ul_port_out  out  2  destination of the current or last admitted packet
- drop_cnt  out  32  count of dropped packets, saturating

Behaviour:
- Capability table:
  - N_DESTS entries of 8 bits, each with a valid bit.
  - When cap_wr=1, entry cap_data[1:0] is loaded with cap_data and its valid bit is set.
  - Writes with an index ≥ N_DESTS are ignored.
  - Written values are visible from the next cycle.
- Route extraction: route = s_tdata[ROUTE_LSB+7:ROUTE_LSB] of the first beat; dest = route[1:0].
- Admit rule: admit iff dest < N_DESTS, entry[dest] is valid, and entry[dest] == route.
- FSM states are IDLE, FWD and DROP.
  - IDLE: s_tready=0 and m_tvalid=0. If s_tvalid=1, evaluate the admit rule combinationally on the held first beat.
    - Admitted: latch dest into dest_q and ul_port_out, then go to FWD.
    - Rejected: go to DROP.
    - The first beat is not consumed in IDLE, so every packet incurs a fixed one-cycle bubble.
  - FWD:
    - m_tvalid[dest_q] = s_tvalid; all other m_tvalid bits are 0.
    - s_tready = m_tready[dest_q].
    - m_tdata, m_tkeep and m_tlast pass s_tdata, s_tkeep and s_tlast through combinationally (zero latency).
    - On a beat with s_tvalid & s_tready & s_tlast, go to IDLE.
  - DROP:
    - s_tready=1 and m_tvalid=0.
    - On the s_tlast handshake: drop_cnt += 1, saturating at 0xFFFFFFFF, then go to IDLE.
- Single-beat packets: IDLE → FWD/DROP → IDLE in exactly 2 cycles when the sink is ready.
- Back-pressure: in FWD the sink may stall indefinitely. Beats are never lost or duplicated, and ul_port_out stays stable.
- Capability write racing a decision:
  - A write in the same cycle as an IDLE decision does not affect that decision; the old table value is used.
  - A write during FWD or DROP affects only later packets.
- Valid bits: entries are never invalidated except by reset.
- AXI rule: m_tvalid must not depend on m_tready.
- Reset (including mid-packet):
  - FSM returns to IDLE, all table entries become invalid, dest_q=0, ul_port_out=0, drop_cnt=0.
  - Outputs are s_tready=0 and m_tvalid=0.
  - A partially forwarded packet is truncated; upstream is responsible for flushing.
- After reset, every packet is dropped until the table is programmed.

Decomposition:
- Shared package (gate_pkg) holds:
  - the route-byte field layout constants: ROUTE_DEST_LSB=0 and ROUTE_DEST_BITS=2;
  - the cap-word typedef, a packed struct with the index and route byte;
  - the FSM state enum, gate_demux_state_t.
- One sub-module, gate_cap_table: the register array, valid bits and the admit compare. It has a write port and a combinational lookup port.
- The demux FSM and the datapath mux stay in the top level.

Test Plan:
- Program the table with cap_data=0x41 (entry 1); send a 3-beat packet with route byte 0x41 and sinks always ready.
  → One bubble cycle, then 3 beats appear on m_tvalid[1] only, with identical data and keep; m_tlast on beat 3; ul_port_out=1.
- With entry 1=0x41, send route byte 0x45 (dest 1, tag mismatch).
  → Packet fully consumed with s_tready=1 and no m_tvalid; drop_cnt goes 0→1.
- Immediately after reset, send route byte 0x00 with no writes done.
  → Packet dropped; drop_cnt=1.
- Admit to dest 2 (cap 0x0A, route 0x0A) as a 4-beat packet; hold m_tready[2]=0 for 5 cycles mid-packet and toggle m_tready[0].
  → No beats lost, s_tready follows m_tready[2], m_tvalid[0] stays 0.
- During FWD of an admitted dest-0 packet, write cap 0x80 (entry 0, route 0x80); then send route 0x00.
  → Current packet completes normally; next packet is dropped.
- Assert aresetn=0 during beat 2 of a 4-beat packet.
  → Next cycle: s_tready=0, m_tvalid=0, ul_port_out=0, drop_cnt=0, and all entries are invalid (a following packet is dropped).
